// File: rtl/arp_tone_pkg.sv
// Shared types and constants for the arpeggiator tone generator.
// Pure declarations: no latency, no flow control.
// The per-note increments are tuned for a 48828.125 Hz sample rate.
package arp_tone_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_t;

    localparam int          PHASE_W = 24;
    localparam logic [14:0] AMP_MAX = 15'd32767;

    // C4, E4, G4, C5 phase increments; index 0 is note0.
    localparam logic [3:0][PHASE_W-1:0] INC = {
        24'd179787, 24'd134690, 24'd113260, 24'd89895
    };

    function automatic logic [1:0] note_sel(input logic [3:0] notes);
        if (notes[0])      return 2'd0;
        else if (notes[1]) return 2'd1;
        else if (notes[2]) return 2'd2;
        else               return 2'd3;
    endfunction

endpackage

// File: rtl/arp_tone_envelope.sv
// Amplitude envelope FSM; ramped attack/release only with ARP_TONE_ENVELOPE_EN.
// Latency: amp/active change on the tick that observes the gate.
// Backpressure: none, advances only on sample ticks.
module arp_tone_envelope #(
    parameter int AMP_STEP = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        gate,
    output logic [14:0] amp,
    output logic        active
);
    import arp_tone_pkg::*;

    env_state_t state;

    if (AMP_STEP < 1 || AMP_STEP > 32767) begin : g_bad_amp_step
        $error("arp_tone_envelope: AMP_STEP must be within 1..32767");
    end

`ifdef ARP_TONE_ENVELOPE_EN
    localparam logic [15:0] STEP16 = 16'(AMP_STEP);

    logic [15:0] up_sum;
    logic [14:0] amp_inc;
    logic [14:0] amp_dec;

    assign up_sum  = {1'b0, amp} + STEP16;
    assign amp_inc = (up_sum >= {1'b0, AMP_MAX}) ? AMP_MAX : up_sum[14:0];
    assign amp_dec = ({1'b0, amp} <= STEP16) ? 15'd0 : 15'({1'b0, amp} - STEP16);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            amp   <= '0;
        end else if (tick) begin
`ifdef ARP_TONE_ENVELOPE_EN
            // A retrigger from RELEASE ramps up from wherever amp currently is.
            if (gate) begin
                amp   <= amp_inc;
                state <= (amp_inc == AMP_MAX) ? SUSTAIN : ATTACK;
            end else if (state != IDLE) begin
                amp   <= amp_dec;
                state <= (amp_dec == 15'd0) ? IDLE : RELEASE;
            end
`else
            amp   <= gate ? AMP_MAX : 15'd0;
            state <= gate ? SUSTAIN : IDLE;
`endif
        end
    end

    assign active = (state != IDLE);

endmodule

// File: rtl/arp_tone_gen.sv
// Square-wave tone generator fed by arpeggiator note gates; envelope ramp via ARP_TONE_ENVELOPE_EN.
// Latency: gate edge acted on at next tick, visible on sample one tick later.
// Backpressure: none, free-running sample strobe every SAMPLE_DIV cycles.
module arp_tone_gen #(
    parameter int SAMPLE_DIV = 1024,
    parameter int AMP_STEP   = 8192
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               Enable,
    input  logic               note0,
    input  logic               note1,
    input  logic               note2,
    input  logic               note3,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    output logic               active,
    output logic [1:0]         note_idx
);
    import arp_tone_pkg::*;

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [3:0]         notes;
    logic               gate;
    logic [1:0]         sel;
    logic [PHASE_W-1:0] phase;
    logic [14:0]        amp;
    logic signed [15:0] amp_s;

    assign notes = {note3, note2, note1, note0};
    assign gate  = Enable && (|notes);
    assign sel   = note_sel(notes);
    assign tick  = (cnt == CNT_W'(SAMPLE_DIV - 1));
    assign amp_s = signed'({1'b0, amp});

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + 1'b1;
    end

    arp_tone_envelope #(
        .AMP_STEP (AMP_STEP)
    ) u_env (
        .clk    (CLK),
        .rst    (RESET),
        .tick   (tick),
        .gate   (gate),
        .amp    (amp),
        .active (active)
    );

    // Sample uses phase/amp as they stood before this tick's update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            note_idx     <= '0;
            phase        <= '0;
        end else begin
            sample_valid <= tick;
            if (tick) begin
                sample <= phase[PHASE_W-1] ? -amp_s : amp_s;
                if (gate) begin
                    note_idx <= sel;
                    // A fresh note from silence starts at phase 0; retriggers stay continuous.
                    phase    <= active ? phase + INC[sel] : '0;
                end
            end
        end
    end

endmodule
